// File: rtl/msmc_pkg.sv
// Shared types and width helpers for the matrix-scalar multiply sequencer.
package msmc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FIN
    } msmc_state_e;

    // Credits range 0..RES_DEPTH inclusive.
    function automatic int cred_width(input int res_depth);
        return $clog2(res_depth + 1);
    endfunction

    // Element count: rows*cols can never overflow at 2*DIM_W bits.
    function automatic int cnt_width(input int dim_w);
        return 2 * dim_w;
    endfunction

endpackage

// File: rtl/msmc_res_fifo.sv
// Result buffer for multiplier products. Head is read straight from the
// storage flops, so wr_data carries no combinational path from the multiplier.
module msmc_res_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // Push into a full buffer is fine when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/matrix_scalar_seq_ctrl.sv
// Matrix-scalar multiply sequencer (C = A * s), credit-limited read issue.
// Optional MSMC_PERF_EN adds perf_cycles / perf_stall counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a job descriptor, cfg_ready high
// ST_ISSUE | issuing reads of A while elements remain and credits allow
// ST_DRAIN | all reads issued, waiting for every product to be written
// ST_FIN   | job complete, done pulses in the following cycle
module matrix_scalar_seq_ctrl
    import msmc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DIM_W     = 8,
    parameter int ADDR_W    = 16,
    parameter int MUL_LAT   = 3,
    parameter int RES_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [DIM_W-1:0]  cfg_cols,
    input  logic [DATA_W-1:0] cfg_scalar,
    input  logic [ADDR_W-1:0] cfg_src_base,
    input  logic [ADDR_W-1:0] cfg_dst_base,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_rsp_valid,
    input  logic [DATA_W-1:0] rd_rsp_data,
    output logic              mul_valid_in,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic              mul_valid_out,
    input  logic [DATA_W-1:0] mul_result,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
`ifdef MSMC_PERF_EN
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall,
`endif
    output logic              busy,
    output logic              done
);

    localparam int CNT_W  = cnt_width(DIM_W);
    localparam int CRED_W = cred_width(RES_DEPTH);

    msmc_state_e       state;
    logic [CNT_W-1:0]  total;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  written;
    logic [CNT_W-1:0]  next_total;
    logic [CRED_W-1:0] credits;
    logic [CRED_W-1:0] rd_outstanding;
    logic [CRED_W-1:0] mul_pending;
    logic [DATA_W-1:0] scalar_q;
    logic [ADDR_W-1:0] src_base_q;
    logic [ADDR_W-1:0] dst_base_q;

    logic accept;
    logic issue_hs;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;

    assign next_total   = CNT_W'(cfg_rows) * CNT_W'(cfg_cols);
    assign cfg_ready    = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign accept       = cfg_valid && cfg_ready;

    assign rd_req_valid = (state == ST_ISSUE) && (issued != total) && (credits != '0);
    assign rd_req_addr  = src_base_q + ADDR_W'(issued);
    assign issue_hs     = rd_req_valid && rd_req_ready;

    // Responses/products with nothing outstanding are leftovers of an aborted job.
    assign mul_valid_in = rd_rsp_valid && (rd_outstanding != '0);
    assign mul_a        = mul_valid_in ? rd_rsp_data : '0;
    assign mul_b        = scalar_q;
    assign fifo_push    = mul_valid_out && (mul_pending != '0);

    assign wr_valid     = !fifo_empty;
    assign wr_addr      = dst_base_q + ADDR_W'(written);
    assign fifo_pop     = wr_valid && wr_ready;

    msmc_res_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RES_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (mul_result),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            total          <= '0;
            issued         <= '0;
            written        <= '0;
            credits        <= CRED_W'(RES_DEPTH);
            rd_outstanding <= '0;
            mul_pending    <= '0;
            scalar_q       <= '0;
            src_base_q     <= '0;
            dst_base_q     <= '0;
            done           <= 1'b0;
        end else begin
            done           <= 1'b0;
            rd_outstanding <= rd_outstanding + CRED_W'(issue_hs) - CRED_W'(mul_valid_in);
            mul_pending    <= mul_pending + CRED_W'(mul_valid_in) - CRED_W'(fifo_push);
            credits        <= credits - CRED_W'(issue_hs) + CRED_W'(fifo_pop);
            if (issue_hs) begin
                issued <= issued + 1'b1;
            end
            if (fifo_pop) begin
                written <= written + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        total      <= next_total;
                        issued     <= '0;
                        written    <= '0;
                        credits    <= CRED_W'(RES_DEPTH);
                        scalar_q   <= cfg_scalar;
                        src_base_q <= cfg_src_base;
                        dst_base_q <= cfg_dst_base;
                        state      <= (next_total == '0) ? ST_FIN : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issued == total) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((written == total) && fifo_empty) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MSMC_PERF_EN
    logic stall_cond;

    assign stall_cond = (state == ST_ISSUE) &&
                        ((rd_req_valid && !rd_req_ready) ||
                         ((credits == '0) && (issued != total)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) begin
                perf_cycles <= perf_cycles + 1'b1;
            end
            if (stall_cond && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 1'b1;
            end
        end
    end
`endif

    a_rsp_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        rd_rsp_valid |-> (rd_outstanding != '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_matrix_scalar_seq_ctrl.sv
// Directed bench for matrix_scalar_seq_ctrl with 2-cycle memory and 3-cycle multiplier models.
module tb_matrix_scalar_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  cfg_rows = '0;
    logic [7:0]  cfg_cols = '0;
    logic [31:0] cfg_scalar = '0;
    logic [15:0] cfg_src_base = '0;
    logic [15:0] cfg_dst_base = '0;
    logic        rd_req_valid;
    logic        rd_req_ready = 1'b1;
    logic [15:0] rd_req_addr;
    logic        rd_rsp_valid;
    logic [31:0] rd_rsp_data;
    logic        mul_valid_in;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_valid_out;
    logic [31:0] mul_result;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic        rand_mode = 1'b0;
    logic        rd_ready_set = 1'b1;
    logic        wr_ready_set = 1'b1;

    logic [31:0] mem_a [65536];
    logic [15:0] rd_log [$];
    logic [15:0] wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    int          done_cnt = 0;

    logic        rv [2];
    logic [31:0] rdat [2];
    logic        mv [3];
    logic [31:0] mdat [3];

    matrix_scalar_seq_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_rows      (cfg_rows),
        .cfg_cols      (cfg_cols),
        .cfg_scalar    (cfg_scalar),
        .cfg_src_base  (cfg_src_base),
        .cfg_dst_base  (cfg_dst_base),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_rsp_valid  (rd_rsp_valid),
        .rd_rsp_data   (rd_rsp_data),
        .mul_valid_in  (mul_valid_in),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_valid_out (mul_valid_out),
        .mul_result    (mul_result),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Fixed 2-cycle read memory and 3-cycle multiplier; both flush on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv[0] <= 1'b0; rv[1] <= 1'b0; rdat[0] <= '0; rdat[1] <= '0;
            for (int i = 0; i < 3; i++) begin
                mv[i]   <= 1'b0;
                mdat[i] <= '0;
            end
        end else begin
            rv[0]   <= rd_req_valid && rd_req_ready;
            rdat[0] <= mem_a[rd_req_addr];
            rv[1]   <= rv[0];
            rdat[1] <= rdat[0];
            mv[0]   <= mul_valid_in;
            mdat[0] <= mul_a * mul_b;
            for (int i = 1; i < 3; i++) begin
                mv[i]   <= mv[i-1];
                mdat[i] <= mdat[i-1];
            end
        end
    end

    assign rd_rsp_valid  = rv[1];
    assign rd_rsp_data   = rv[1] ? rdat[1] : '0;
    assign mul_valid_out = mv[2];
    assign mul_result    = mdat[2];

    always @(posedge clk) begin
        if (rst_n && rd_req_valid && rd_req_ready) rd_log.push_back(rd_req_addr);
        if (rst_n && wr_valid && wr_ready) begin
            wr_addr_log.push_back(wr_addr);
            wr_data_log.push_back(wr_data);
        end
        if (done) done_cnt++;
    end

    always @(negedge clk) begin
        rd_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : rd_ready_set;
        wr_ready     = rand_mode ? 1'($urandom_range(0, 1)) : wr_ready_set;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    task automatic start_job(input logic [7:0] rows, input logic [7:0] cols,
                             input logic [31:0] s, input logic [15:0] src,
                             input logic [15:0] dst);
        @(negedge clk);
        cfg_rows = rows; cfg_cols = cols; cfg_scalar = s;
        cfg_src_base = src; cfg_dst_base = dst;
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until done is seen high.
    task automatic wait_done(input string tag, input int budget, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < budget) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic check_writes(input string tag, input int n, input logic [15:0] dst,
                                input logic [15:0] src, input logic [31:0] s);
        check({tag, "_wr_count"}, 64'(wr_addr_log.size()), 64'(n));
        for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
            check({tag, "_wr_addr"}, 64'(wr_addr_log[i]), 64'(16'(dst + 16'(i))));
            check({tag, "_wr_data"}, 64'(wr_data_log[i]), 64'(32'(mem_a[16'(src + 16'(i))] * s)));
        end
    endtask

    initial begin
        int lat;
        int done_before;

        for (int i = 0; i < 6; i++)  mem_a[16'h0010 + i] = 32'(i + 1);
        for (int i = 0; i < 16; i++) mem_a[16'h0100 + i] = 32'(i * 3 + 7);
        mem_a[16'hFFFE] = 32'd9; mem_a[16'hFFFF] = 32'd8;
        mem_a[16'h0000] = 32'd7; mem_a[16'h0001] = 32'd6;
        mem_a[16'h0900] = 32'd2;
        for (int i = 0; i < 64; i++) mem_a[16'h0200 + i] = 32'(i * i + 1);
        for (int i = 0; i < 4; i++)  mem_a[16'h0500 + i] = 32'(i + 100);

        // Reset values
        #12;
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_req_valid", 64'(rd_req_valid), 64'd0);
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mul_valid_in", 64'(mul_valid_in), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 2x3, scalar 5: expect 5,10,..,30 at 0x40..0x45
        clear_logs();
        start_job(8'd2, 8'd3, 32'd5, 16'h0010, 16'h0040);
        check("j1_busy", 64'(busy), 64'd1);
        wait_done("j1", 200, lat);
        check("j1_cfg_ready", 64'(cfg_ready), 64'd1);
        check("j1_busy_end", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("j1_done_one_cycle", 64'(done), 64'd0);
        check("j1_done_count", 64'(done_cnt), 64'd1);
        check_writes("j1", 6, 16'h0040, 16'h0010, 32'd5);
        for (int i = 0; i < 6; i++)
            if (i < wr_data_log.size()) check("j1_value", 64'(wr_data_log[i]), 64'(5 * (i + 1)));

        // rows=0: no traffic, done two cycles after the accept cycle
        clear_logs();
        start_job(8'd0, 8'd7, 32'd3, 16'h0010, 16'h0040);
        wait_done("zero", 20, lat);
        check("zero_done_lat", 64'(lat), 64'd1);
        check("zero_reads", 64'(rd_log.size()), 64'd0);
        check("zero_writes", 64'(wr_addr_log.size()), 64'd0);

        // 4x4 with writes blocked: credits cap reads at RES_DEPTH
        clear_logs();
        wr_ready_set = 1'b0;
        @(negedge clk);
        start_job(8'd4, 8'd4, 32'd3, 16'h0100, 16'h0180);
        repeat (20) @(posedge clk); #1;
        check("stall_reads", 64'(rd_log.size()), 64'd4);
        check("stall_rd_req_valid", 64'(rd_req_valid), 64'd0);
        check("stall_wr_valid", 64'(wr_valid), 64'd1);
        wr_ready_set = 1'b1;
        wait_done("stall", 400, lat);
        check_writes("stall", 16, 16'h0180, 16'h0100, 32'd3);

        // Source address wraps at the top of memory
        clear_logs();
        start_job(8'd1, 8'd4, 32'd1, 16'hFFFE, 16'h0800);
        wait_done("wrap", 200, lat);
        check("wrap_reads", 64'(rd_log.size()), 64'd4);
        if (rd_log.size() == 4) begin
            check("wrap_addr0", 64'(rd_log[0]), 64'hFFFE);
            check("wrap_addr1", 64'(rd_log[1]), 64'hFFFF);
            check("wrap_addr2", 64'(rd_log[2]), 64'h0000);
            check("wrap_addr3", 64'(rd_log[3]), 64'h0001);
        end
        check_writes("wrap", 4, 16'h0800, 16'hFFFE, 32'd1);

        // Product keeps only the low bits
        clear_logs();
        start_job(8'd1, 8'd1, 32'hFFFF_FFFF, 16'h0900, 16'h0A00);
        wait_done("lowbits", 100, lat);
        check("lowbits_count", 64'(wr_data_log.size()), 64'd1);
        if (wr_data_log.size() > 0) check("lowbits_data", 64'(wr_data_log[0]), 64'hFFFF_FFFE);

        // 8x8 with random ready on both sides
        clear_logs();
        rand_mode = 1'b1;
        start_job(8'd8, 8'd8, 32'h11, 16'h0200, 16'h0300);
        wait_done("rand", 3000, lat);
        rand_mode = 1'b0;
        check_writes("rand", 64, 16'h0300, 16'h0200, 32'h11);

        // Reset while draining with writes blocked
        clear_logs();
        wr_ready_set = 1'b0;
        @(negedge clk);
        start_job(8'd1, 8'd4, 32'd2, 16'h0500, 16'h0600);
        repeat (15) @(posedge clk); #1;
        check("abort_busy_before", 64'(busy), 64'd1);
        check("abort_wr_valid_before", 64'(wr_valid), 64'd1);
        done_before = done_cnt;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_cfg_ready", 64'(cfg_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_wr_valid", 64'(wr_valid), 64'd0);
        check("abort_rd_req_valid", 64'(rd_req_valid), 64'd0);
        check("abort_wr_addr", 64'(wr_addr), 64'd0);
        wr_ready_set = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("abort_no_done", 64'(done_cnt), 64'(done_before));
        check("abort_writes", 64'(wr_addr_log.size()), 64'd0);

        clear_logs();
        start_job(8'd2, 8'd2, 32'd4, 16'h0500, 16'h0700);
        wait_done("post", 200, lat);
        check_writes("post", 4, 16'h0700, 16'h0500, 32'd4);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
